// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  // Latency counter width; out-of-range latencies are sized as the nearest legal one
  function automatic int lat_cnt_width(input int mem_lat);
    int lat_s;
    if (mem_lat < MEM_LAT_MIN) begin
      lat_s = MEM_LAT_MIN;
    end else if (mem_lat > MEM_LAT_MAX) begin
      lat_s = MEM_LAT_MAX;
    end else begin
      lat_s = mem_lat;
    end
    return $clog2(lat_s + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin picker: purely combinational, one-hot grant.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic [1:0] gnt_s;

  // Lone requester wins; on a conflict the one not served last wins
  always_comb begin
    gnt_s = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (last_gnt == REQ_DBG) ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store path (0) and the debug loader (1).
// Writes issue in one cycle; a single read is tracked until its data returns.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = lat_cnt_width(MEM_LAT);

  arb_state_e        state_r, state_nxt_s;
  logic              last_gnt_r, last_gnt_nxt_s;
  logic              owner_r, owner_nxt_s;
  logic [CNT_W-1:0]  lat_cnt_r, lat_cnt_nxt_s;
  logic              r0_rvalid_r, r0_rvalid_nxt_s;
  logic              r1_rvalid_r, r1_rvalid_nxt_s;
  logic [DATA_W-1:0] r0_rdata_r, r0_rdata_nxt_s;
  logic [DATA_W-1:0] r1_rdata_r, r1_rdata_nxt_s;

  logic [1:0]        gnt_s;
  logic              any_gnt_s;
  logic              gnt_id_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  rr_arbiter2 u_rr (
    .req      ({r1_req, r0_req}),
    .last_gnt (last_gnt_r),
    .enable   (state_r == IDLE),
    .gnt      (gnt_s)
  );

  assign any_gnt_s = gnt_s[0] | gnt_s[1];
  assign gnt_id_s  = gnt_s[1] ? REQ_DBG : REQ_CORE;

  // Steer the granted requester onto the memory port
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = r0_addr;
    mem_wdata_s = r0_wdata;
    if (gnt_s[1]) begin
      mem_we_s    = r1_we;
      mem_addr_s  = r1_addr;
      mem_wdata_s = r1_wdata;
    end else if (gnt_s[0]) begin
      mem_we_s    = r0_we;
      mem_addr_s  = r0_addr;
      mem_wdata_s = r0_wdata;
    end else begin
      mem_we_s    = 1'b0;
      mem_addr_s  = r0_addr;
      mem_wdata_s = r0_wdata;
    end
  end

  // Next-state: issue from IDLE, count read latency, route return data to owner
  always_comb begin
    state_nxt_s     = state_r;
    last_gnt_nxt_s  = last_gnt_r;
    owner_nxt_s     = owner_r;
    lat_cnt_nxt_s   = lat_cnt_r;
    r0_rvalid_nxt_s = 1'b0;
    r1_rvalid_nxt_s = 1'b0;
    r0_rdata_nxt_s  = r0_rdata_r;
    r1_rdata_nxt_s  = r1_rdata_r;
    case (state_r)
      IDLE: begin
        if (any_gnt_s) begin
          last_gnt_nxt_s = gnt_id_s;
          if (!mem_we_s) begin
            state_nxt_s   = READ_WAIT;
            owner_nxt_s   = gnt_id_s;
            lat_cnt_nxt_s = CNT_W'(1);
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ_WAIT: begin
        if (lat_cnt_r == CNT_W'(MEM_LAT)) begin
          state_nxt_s   = IDLE;
          lat_cnt_nxt_s = '0;
          if (owner_r == REQ_DBG) begin
            r1_rvalid_nxt_s = 1'b1;
            r1_rdata_nxt_s  = mem_rdata;
          end else begin
            r0_rvalid_nxt_s = 1'b1;
            r0_rdata_nxt_s  = mem_rdata;
          end
        end else begin
          lat_cnt_nxt_s = lat_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        lat_cnt_nxt_s = '0;
      end
    endcase
  end

  // State and return registers; reset aborts any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      last_gnt_r  <= REQ_DBG;
      owner_r     <= REQ_CORE;
      lat_cnt_r   <= '0;
      r0_rvalid_r <= 1'b0;
      r1_rvalid_r <= 1'b0;
      r0_rdata_r  <= '0;
      r1_rdata_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      last_gnt_r  <= last_gnt_nxt_s;
      owner_r     <= owner_nxt_s;
      lat_cnt_r   <= lat_cnt_nxt_s;
      r0_rvalid_r <= r0_rvalid_nxt_s;
      r1_rvalid_r <= r1_rvalid_nxt_s;
      r0_rdata_r  <= r0_rdata_nxt_s;
      r1_rdata_r  <= r1_rdata_nxt_s;
    end
  end

  assign r0_gnt    = gnt_s[0];
  assign r1_gnt    = gnt_s[1];
  assign r0_rvalid = r0_rvalid_r;
  assign r1_rvalid = r1_rvalid_r;
  assign r0_rdata  = r0_rdata_r;
  assign r1_rdata  = r1_rdata_r;
  assign mem_en    = any_gnt_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign busy      = (state_r == READ_WAIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model, on instances with MEM_LAT=1 (index 0) and MEM_LAT=3 (index 1).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        r0_req [2], r0_we [2], r1_req [2], r1_we [2];
  logic [31:0] r0_addr [2], r0_wdata [2], r1_addr [2], r1_wdata [2];
  logic        r0_gnt [2], r1_gnt [2], r0_rvalid [2], r1_rvalid [2];
  logic        mem_en [2], mem_we [2], busy [2];
  logic [31:0] r0_rdata [2], r1_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .r0_req(r0_req[0]), .r0_we(r0_we[0]), .r0_addr(r0_addr[0]), .r0_wdata(r0_wdata[0]),
    .r0_gnt(r0_gnt[0]), .r0_rvalid(r0_rvalid[0]), .r0_rdata(r0_rdata[0]),
    .r1_req(r1_req[0]), .r1_we(r1_we[0]), .r1_addr(r1_addr[0]), .r1_wdata(r1_wdata[0]),
    .r1_gnt(r1_gnt[0]), .r1_rvalid(r1_rvalid[0]), .r1_rdata(r1_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .r0_req(r0_req[1]), .r0_we(r0_we[1]), .r0_addr(r0_addr[1]), .r0_wdata(r0_wdata[1]),
    .r0_gnt(r0_gnt[1]), .r0_rvalid(r0_rvalid[1]), .r0_rdata(r0_rdata[1]),
    .r1_req(r1_req[1]), .r1_we(r1_we[1]), .r1_addr(r1_addr[1]), .r1_wdata(r1_wdata[1]),
    .r1_gnt(r1_gnt[1]), .r1_rvalid(r1_rvalid[1]), .r1_rdata(r1_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Word-addressed memories (16 words) with read data delayed by the instance latency
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [16];
    logic [31:0] pipe [4];
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g][5:2]] <= mem_wdata[g];
      pipe[0] <= mem[mem_addr[g][5:2]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      r0_req[k] = 1'b0; r0_we[k] = 1'b0; r0_addr[k] = 32'h0; r0_wdata[k] = 32'h0;
      r1_req[k] = 1'b0; r1_we[k] = 1'b0; r1_addr[k] = 32'h0; r1_wdata[k] = 32'h0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1; idle_all();
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_all();
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy[k], r0_rvalid[k], r1_rvalid[k], r0_gnt[k], r1_gnt[k]} !== 5'b0) begin
        errors++; $display("FAIL reset_flags k=%0d: got %b expected 00000", k,
                           {busy[k], r0_rvalid[k], r1_rvalid[k], r0_gnt[k], r1_gnt[k]});
      end
      checks++;
      if ({r0_rdata[k], r1_rdata[k]} !== 64'h0) begin
        errors++; $display("FAIL reset_rdata k=%0d: got %h %h expected 0 0", k, r0_rdata[k], r1_rdata[k]);
      end
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clk);
    r0_req[0] = 1'b1; r0_we[0] = 1'b1; r0_addr[0] = 32'h10; r0_wdata[0] = 32'hDEADBEEF; #1;
    checks++;
    if ({r0_gnt[0], r1_gnt[0], mem_en[0], mem_we[0], busy[0]} !== 5'b10110) begin
      errors++; $display("FAIL write_ctrl: got %b expected 10110",
                         {r0_gnt[0], r1_gnt[0], mem_en[0], mem_we[0], busy[0]});
    end
    checks++;
    if ({mem_addr[0], mem_wdata[0]} !== {32'h10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL write_bus: got %h/%h expected 00000010/deadbeef", mem_addr[0], mem_wdata[0]);
    end
    @(negedge clk); idle_all(); #1;
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL write_busy: got %b expected 0", busy[0]);
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    r1_req[0] = 1'b1; r1_we[0] = 1'b0; r1_addr[0] = 32'h10; #1;
    checks++;
    if ({r1_gnt[0], r0_gnt[0], mem_en[0], mem_we[0], busy[0]} !== 5'b10100) begin
      errors++; $display("FAIL read_issue: got %b expected 10100",
                         {r1_gnt[0], r0_gnt[0], mem_en[0], mem_we[0], busy[0]});
    end
    @(negedge clk); idle_all(); #1;
    checks++;
    if ({busy[0], r0_rvalid[0], r1_rvalid[0]} !== 3'b100) begin
      errors++; $display("FAIL read_wait: got %b expected 100", {busy[0], r0_rvalid[0], r1_rvalid[0]});
    end
    @(negedge clk); #1;
    checks++;
    if ({busy[0], r0_rvalid[0], r1_rvalid[0]} !== 3'b001) begin
      errors++; $display("FAIL read_ret: got %b expected 001", {busy[0], r0_rvalid[0], r1_rvalid[0]});
    end
    checks++;
    if (r1_rdata[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data: got %h expected deadbeef", r1_rdata[0]);
    end
    @(negedge clk); #1;
    checks++;
    if ({r0_rvalid[0], r1_rvalid[0], r1_rdata[0]} !== {2'b00, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_hold: got %b %h expected 00 deadbeef",
                         {r0_rvalid[0], r1_rvalid[0]}, r1_rdata[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r0_req[0] = 1'b1; r0_we[0] = 1'b1; r0_addr[0] = 32'h40; r0_wdata[0] = 32'(i);
      r1_req[0] = 1'b1; r1_we[0] = 1'b1; r1_addr[0] = 32'h44; r1_wdata[0] = 32'(i + 100);
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({r1_gnt[0], r0_gnt[0]} !== exp_g) begin
        errors++; $display("FAIL rr_grant cycle=%0d: got %b expected %b", i, {r1_gnt[0], r0_gnt[0]}, exp_g);
      end
    end
    @(negedge clk); idle_all();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    r0_req[0] = 1'b1; r0_we[0] = 1'b0; r0_addr[0] = 32'h10; #1;
    checks++;
    if (r0_gnt[0] !== 1'b1) begin
      errors++; $display("FAIL block_issue: got %b expected 1", r0_gnt[0]);
    end
    @(negedge clk);
    r0_req[0] = 1'b0;
    r1_req[0] = 1'b1; r1_we[0] = 1'b1; r1_addr[0] = 32'h48; r1_wdata[0] = 32'h55; #1;
    checks++;
    if ({r1_gnt[0], busy[0]} !== 2'b01) begin
      errors++; $display("FAIL block_hold: got %b expected 01", {r1_gnt[0], busy[0]});
    end
    @(negedge clk); #1;
    checks++;
    if ({r1_gnt[0], r0_rvalid[0], busy[0], r0_rdata[0]} !== {3'b110, 32'hDEADBEEF}) begin
      errors++; $display("FAIL block_release: got %b %h expected 110 deadbeef",
                         {r1_gnt[0], r0_rvalid[0], busy[0]}, r0_rdata[0]);
    end
    @(negedge clk); idle_all();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    r0_req[0] = 1'b1; r0_we[0] = 1'b0; r0_addr[0] = 32'h10; #1;
    checks++;
    if (r0_gnt[0] !== 1'b1) begin
      errors++; $display("FAIL abort_issue: got %b expected 1", r0_gnt[0]);
    end
    @(negedge clk); idle_all(); reset = 1'b1; #1;
    checks++;
    if ({busy[0], r0_rvalid[0], r1_rvalid[0], r0_rdata[0]} !== 35'h0) begin
      errors++; $display("FAIL abort_reset: got %b %h expected 000 0",
                         {busy[0], r0_rvalid[0], r1_rvalid[0]}, r0_rdata[0]);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if ({busy[0], r0_rvalid[0], r1_rvalid[0]} !== 3'b000) begin
        errors++; $display("FAIL abort_quiet cycle=%0d: got %b expected 000", i,
                           {busy[0], r0_rvalid[0], r1_rvalid[0]});
      end
    end
    @(negedge clk);
    r0_req[0] = 1'b1; r0_we[0] = 1'b1; r0_addr[0] = 32'h4C; r0_wdata[0] = 32'h1;
    r1_req[0] = 1'b1; r1_we[0] = 1'b1; r1_addr[0] = 32'h50; r1_wdata[0] = 32'h2; #1;
    checks++;
    if ({r1_gnt[0], r0_gnt[0]} !== 2'b01) begin
      errors++; $display("FAIL abort_first_gnt: got %b expected 01", {r1_gnt[0], r0_gnt[0]});
    end
    @(negedge clk); idle_all();
  endtask

  task automatic test_latency3();
    @(negedge clk);
    r1_req[1] = 1'b1; r1_we[1] = 1'b1; r1_addr[1] = 32'h30; r1_wdata[1] = 32'h12345678; #1;
    checks++;
    if (r1_gnt[1] !== 1'b1) begin
      errors++; $display("FAIL lat3_preload: got %b expected 1", r1_gnt[1]);
    end
    @(negedge clk);
    r1_req[1] = 1'b0;
    r0_req[1] = 1'b1; r0_we[1] = 1'b0; r0_addr[1] = 32'h30; #1;
    checks++;
    if (r0_gnt[1] !== 1'b1) begin
      errors++; $display("FAIL lat3_issue: got %b expected 1", r0_gnt[1]);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      r0_req[1] = 1'b0;
      r1_req[1] = 1'b1; r1_we[1] = 1'b1; r1_addr[1] = 32'h34; r1_wdata[1] = 32'h9; #1;
      checks++;
      if ({r0_gnt[1], r1_gnt[1], r0_rvalid[1], busy[1]} !== 4'b0001) begin
        errors++; $display("FAIL lat3_wait G+%0d: got %b expected 0001", c,
                           {r0_gnt[1], r1_gnt[1], r0_rvalid[1], busy[1]});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({r0_rvalid[1], r1_gnt[1], busy[1], r0_rdata[1]} !== {3'b110, 32'h12345678}) begin
      errors++; $display("FAIL lat3_return: got %b %h expected 110 12345678",
                         {r0_rvalid[1], r1_gnt[1], busy[1]}, r0_rdata[1]);
    end
    @(negedge clk); idle_all(); #1;
    checks++;
    if (r0_rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL lat3_single: got %b expected 0", r0_rvalid[1]);
    end
  endtask

  // Transaction-level model state: per instance k, per requester n
  logic        pend [2][2];
  logic        pwe [2][2];
  logic [31:0] paddr [2][2];
  logic [31:0] pwdata [2][2];
  logic [31:0] ref_mem [2][16];
  logic [31:0] hold [2][2];
  logic        m_last [2];
  logic        rv_own [2];
  logic [31:0] rv_dat [2];
  int          idle_from [2];
  int          rv_cyc [2];
  int          pre [2];

  task automatic test_random();
    logic       idle, eg0, eg1, erv0, erv1, gid;
    int         lat;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 2; n++) begin
        pend[k][n] = 1'b0; hold[k][n] = 32'h0;
      end
      m_last[k] = 1'b1; idle_from[k] = 0; rv_cyc[k] = -1; pre[k] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (pre[k] < 16) begin
          if (!pend[k][1]) begin
            pend[k][1] = 1'b1; pwe[k][1] = 1'b1;
            paddr[k][1] = 32'(pre[k]) << 2; pwdata[k][1] = $urandom;
            pre[k]++;
          end
        end else begin
          for (int n = 0; n < 2; n++) begin
            if (!pend[k][n]) begin
              if ($urandom_range(0, 1) == 1) begin
                pend[k][n] = 1'b1; pwe[k][n] = ($urandom_range(0, 1) == 1);
                paddr[k][n] = 32'($urandom_range(0, 15)) << 2; pwdata[k][n] = $urandom;
              end
            end else if ($urandom_range(0, 15) == 0) begin
              pend[k][n] = 1'b0;
            end
          end
        end
        r0_req[k] = pend[k][0]; r0_we[k] = pwe[k][0]; r0_addr[k] = paddr[k][0]; r0_wdata[k] = pwdata[k][0];
        r1_req[k] = pend[k][1]; r1_we[k] = pwe[k][1]; r1_addr[k] = paddr[k][1]; r1_wdata[k] = pwdata[k][1];
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        lat  = (k == 0) ? 1 : 3;
        idle = (cyc >= idle_from[k]);
        if (idle && pend[k][0] && pend[k][1]) begin
          eg0 = m_last[k]; eg1 = !m_last[k];
        end else begin
          eg0 = idle && pend[k][0]; eg1 = idle && pend[k][1];
        end
        erv0 = (cyc == rv_cyc[k]) && (rv_own[k] == 1'b0);
        erv1 = (cyc == rv_cyc[k]) && (rv_own[k] == 1'b1);
        if (erv0) hold[k][0] = rv_dat[k];
        if (erv1) hold[k][1] = rv_dat[k];
        checks++;
        if ({r1_gnt[k], r0_gnt[k], mem_en[k], busy[k], r1_rvalid[k], r0_rvalid[k]} !==
            {eg1, eg0, eg0 | eg1, !idle, erv1, erv0}) begin
          errors++; $display("FAIL rand_ctrl k=%0d cyc=%0d: got %b expected %b", k, cyc,
                             {r1_gnt[k], r0_gnt[k], mem_en[k], busy[k], r1_rvalid[k], r0_rvalid[k]},
                             {eg1, eg0, eg0 | eg1, !idle, erv1, erv0});
        end
        checks++;
        if ({r0_rdata[k], r1_rdata[k]} !== {hold[k][0], hold[k][1]}) begin
          errors++; $display("FAIL rand_rdata k=%0d cyc=%0d: got %h %h expected %h %h", k, cyc,
                             r0_rdata[k], r1_rdata[k], hold[k][0], hold[k][1]);
        end
        if (eg0 || eg1) begin
          gid = eg1;
          checks++;
          if ({mem_we[k], mem_addr[k], mem_wdata[k]} !== {pwe[k][gid], paddr[k][gid], pwdata[k][gid]}) begin
            errors++; $display("FAIL rand_bus k=%0d cyc=%0d: got %b %h %h expected %b %h %h", k, cyc,
                               mem_we[k], mem_addr[k], mem_wdata[k], pwe[k][gid], paddr[k][gid], pwdata[k][gid]);
          end
          m_last[k] = gid;
          pend[k][gid] = 1'b0;
          if (pwe[k][gid]) begin
            ref_mem[k][paddr[k][gid][5:2]] = pwdata[k][gid];
          end else begin
            idle_from[k] = cyc + lat + 1;
            rv_cyc[k]    = cyc + lat + 1;
            rv_own[k]    = gid;
            rv_dat[k]    = ref_mem[k][paddr[k][gid][5:2]];
          end
        end
      end
    end
    @(negedge clk); idle_all();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_read();
    test_latency3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
